// File: rtl/pkt_classifier.sv
// Ingress header classifier: SDP/MDP/BDP/ERR typing, src/tgt validation, saturating stats.
// Latency 1 cycle; in_ready = !rst && (!out_valid || out_ready), so the stage runs at full throughput.
module pkt_classifier #(
  parameter int NUM_PORTS = 4,
  parameter int CNT_W     = 16,
  parameter int DROP_ERR  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NUM_PORTS-1:0] in_source,
  input  logic [NUM_PORTS-1:0] in_target,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM_PORTS-1:0] out_source,
  output logic [NUM_PORTS-1:0] out_target,
  output logic [1:0]           out_type,
  output logic                 out_ok,
  input  logic                 stat_clr,
  output logic [CNT_W-1:0]     cnt_sdp,
  output logic [CNT_W-1:0]     cnt_mdp,
  output logic [CNT_W-1:0]     cnt_bdp,
  output logic [CNT_W-1:0]     cnt_err
);

  typedef enum logic [1:0] {
    PT_SDP = 2'd0,
    PT_MDP = 2'd1,
    PT_BDP = 2'd2,
    PT_ERR = 2'd3
  } pkt_type_e;

  localparam int PCW = $clog2(NUM_PORTS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic logic [PCW-1:0] popcnt(input logic [NUM_PORTS-1:0] v);
    logic [PCW-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_PORTS; i++) c = c + PCW'(v[i]);
    return c;
  endfunction

  logic [PCW-1:0] src_cnt, tgt_cnt;
  pkt_type_e      cls_type;
  logic           cls_ok;

  always_comb begin
    src_cnt  = popcnt(in_source);
    tgt_cnt  = popcnt(in_target);
    cls_type = PT_ERR;
    if (src_cnt == PCW'(1) && tgt_cnt != '0) begin
      if (tgt_cnt == PCW'(1))              cls_type = PT_SDP;
      else if (tgt_cnt == PCW'(NUM_PORTS)) cls_type = PT_BDP;
      else                                 cls_type = PT_MDP;
    end
    // Broadcast is allowed to hit its own source port; unicast/multicast are not.
    cls_ok = (cls_type != PT_ERR) &&
             (((in_source & in_target) == '0) || (cls_type == PT_BDP));
  end

  logic                 out_valid_q, out_valid_d;
  logic [NUM_PORTS-1:0] out_source_q, out_source_d;
  logic [NUM_PORTS-1:0] out_target_q, out_target_d;
  pkt_type_e            out_type_q, out_type_d;
  logic                 out_ok_q, out_ok_d;
  logic                 accept, load;

  assign in_ready = !rst && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign load     = accept && (cls_ok || (DROP_ERR == 0));

  always_comb begin
    out_valid_d  = out_valid_q;
    out_source_d = out_source_q;
    out_target_d = out_target_q;
    out_type_d   = out_type_q;
    out_ok_d     = out_ok_q;
    if (load) begin
      out_valid_d  = 1'b1;
      out_source_d = in_source;
      out_target_d = in_target;
      out_type_d   = cls_type;
      out_ok_d     = cls_ok;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_source_q <= '0;
      out_target_q <= '0;
      out_type_q   <= PT_ERR;
      out_ok_q     <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_source_q <= out_source_d;
      out_target_q <= out_target_d;
      out_type_q   <= out_type_d;
      out_ok_q     <= out_ok_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_source = out_source_q;
  assign out_target = out_target_q;
  assign out_type   = out_type_q;
  assign out_ok     = out_ok_q;

  // Counters indexed by type; invalid packets always land in the ERR slot.
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [1:0]       inc_idx;

  assign inc_idx = cls_ok ? cls_type : PT_ERR;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (stat_clr)
        cnt_d[i] = '0;
      else if (accept && inc_idx == 2'(i) && cnt_q[i] != CNT_MAX)
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign cnt_sdp = cnt_q[0];
  assign cnt_mdp = cnt_q[1];
  assign cnt_bdp = cnt_q[2];
  assign cnt_err = cnt_q[3];

endmodule

// File: tb/tb_pkt_classifier.sv
// Bench for pkt_classifier: instance A (CNT_W=4, forward errors), instance B (DROP_ERR=1).
// Expected headers are queued at accept time and popped when each DUT transfers output.
module tb_pkt_classifier;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 1, a_out_ok, a_stat_clr = 0;
  logic [3:0] a_in_source = 0, a_in_target = 0, a_out_source, a_out_target;
  logic [1:0] a_out_type;
  logic [3:0] a_cnt_sdp, a_cnt_mdp, a_cnt_bdp, a_cnt_err;

  logic        b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 1, b_out_ok, b_stat_clr = 0;
  logic [3:0]  b_in_source = 0, b_in_target = 0, b_out_source, b_out_target;
  logic [1:0]  b_out_type;
  logic [15:0] b_cnt_sdp, b_cnt_mdp, b_cnt_bdp, b_cnt_err;

  pkt_classifier #(.NUM_PORTS(4), .CNT_W(4), .DROP_ERR(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_source(a_in_source), .in_target(a_in_target), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_source(a_out_source), .out_target(a_out_target),
    .out_type(a_out_type), .out_ok(a_out_ok), .stat_clr(a_stat_clr),
    .cnt_sdp(a_cnt_sdp), .cnt_mdp(a_cnt_mdp), .cnt_bdp(a_cnt_bdp), .cnt_err(a_cnt_err));

  pkt_classifier #(.NUM_PORTS(4), .CNT_W(16), .DROP_ERR(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_source(b_in_source), .in_target(b_in_target), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_source(b_out_source), .out_target(b_out_target),
    .out_type(b_out_type), .out_ok(b_out_ok), .stat_clr(b_stat_clr),
    .cnt_sdp(b_cnt_sdp), .cnt_mdp(b_cnt_mdp), .cnt_bdp(b_cnt_bdp), .cnt_err(b_cnt_err));

  typedef struct packed {
    logic [3:0] src;
    logic [3:0] tgt;
    logic [1:0] typ;
    logic       ok;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int checks = 0;
  int errors = 0;
  int a_seen = 0;
  int b_seen = 0;

  function automatic exp_t model(input logic [3:0] s, input logic [3:0] t);
    exp_t e;
    int sc, tc;
    sc = $countones(s);
    tc = $countones(t);
    e.src = s;
    e.tgt = t;
    if (sc != 1 || tc == 0) e.typ = 2'd3;
    else if (tc == 1)       e.typ = 2'd0;
    else if (tc == 4)       e.typ = 2'd2;
    else                    e.typ = 2'd1;
    e.ok = (e.typ != 2'd3) && (((s & t) == 4'd0) || e.typ == 2'd2);
    return e;
  endfunction

  // Scoreboard push on accept (sampled mid-cycle, before the accepting edge).
  always @(negedge clk) begin
    if (!rst && a_in_valid && a_in_ready) qa.push_back(model(a_in_source, a_in_target));
    if (!rst && b_in_valid && b_in_ready) begin
      exp_t e;
      e = model(b_in_source, b_in_target);
      if (e.ok) qb.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (a_out_valid && a_out_ready) begin
      exp_t e, g;
      a_seen++;
      checks++;
      g = '{a_out_source, a_out_target, a_out_type, a_out_ok};
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL sb_a_unexpected: got %h, queue empty", g);
      end else begin
        e = qa.pop_front();
        if (g !== e) begin
          errors++;
          $display("FAIL sb_a_data: got %h expected %h", g, e);
        end
      end
    end
    if (b_out_valid && b_out_ready) begin
      exp_t e, g;
      b_seen++;
      checks++;
      g = '{b_out_source, b_out_target, b_out_type, b_out_ok};
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL sb_b_unexpected: got %h, queue empty", g);
      end else begin
        e = qb.pop_front();
        if (g !== e) begin
          errors++;
          $display("FAIL sb_b_data: got %h expected %h", g, e);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send_a(input logic [3:0] s, input logic [3:0] t);
    int n = 0;
    a_in_source = s; a_in_target = t; a_in_valid = 1'b1;
    @(negedge clk);
    while (!a_in_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!a_in_ready) begin errors++; $display("FAIL send_a_timeout: in_ready=%b required 1", a_in_ready); end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [3:0] s, input logic [3:0] t);
    int n = 0;
    b_in_source = s; b_in_target = t; b_in_valid = 1'b1;
    @(negedge clk);
    while (!b_in_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!b_in_ready) begin errors++; $display("FAIL send_b_timeout: in_ready=%b required 1", b_in_ready); end
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({a_in_ready, a_out_valid, a_out_ok, b_in_ready, b_out_valid} !== 5'b0) begin
      errors++; $display("FAIL reset_ctl: got %b required 00000",
                         {a_in_ready, a_out_valid, a_out_ok, b_in_ready, b_out_valid});
    end
    checks++;
    if ({a_out_source, a_out_target, a_out_type} !== 10'b0000_0000_11) begin
      errors++; $display("FAIL reset_out: got %b required 0000000011", {a_out_source, a_out_target, a_out_type});
    end
    checks++;
    if ({a_cnt_sdp, a_cnt_mdp, a_cnt_bdp, a_cnt_err} !== 16'd0) begin
      errors++; $display("FAIL reset_cnt: got %h required 0", {a_cnt_sdp, a_cnt_mdp, a_cnt_bdp, a_cnt_err});
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_classify;
    logic [3:0] src_tab [7] = '{4'b0001, 4'b0010, 4'b0001, 4'b0011, 4'b0000, 4'b0001, 4'b0100};
    logic [3:0] tgt_tab [7] = '{4'b0010, 4'b1111, 4'b0011, 4'b0100, 4'b0001, 4'b0000, 4'b1011};
    logic [2:0] res_tab [7] = '{3'b001, 3'b101, 3'b010, 3'b110, 3'b110, 3'b110, 3'b011};
    for (int i = 0; i < 7; i++) begin
      send_a(src_tab[i], tgt_tab[i]);
      checks++;
      if ({a_out_valid, a_out_type, a_out_ok} !== {1'b1, res_tab[i]}) begin
        errors++; $display("FAIL classify_%0d: got vld/type/ok %b required %b",
                           i, {a_out_valid, a_out_type, a_out_ok}, {1'b1, res_tab[i]});
      end
    end
    checks++;
    if ({a_cnt_sdp, a_cnt_mdp, a_cnt_bdp, a_cnt_err} !== {4'd1, 4'd1, 4'd1, 4'd4}) begin
      errors++; $display("FAIL classify_cnt: got %h required 1114", {a_cnt_sdp, a_cnt_mdp, a_cnt_bdp, a_cnt_err});
    end
    @(posedge clk); #1;
    checks++;
    if (a_out_valid !== 1'b0) begin errors++; $display("FAIL classify_drain: out_valid=%b required 0", a_out_valid); end
  endtask

  task automatic test_back_to_back;
    int seen0 = a_seen;
    for (int i = 0; i < 10; i++) send_a(4'($urandom), 4'($urandom));
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (a_seen - seen0 != 10 || qa.size() != 0) begin
      errors++; $display("FAIL b2b_count: outputs %0d queue %0d required 10 and 0", a_seen - seen0, qa.size());
    end
  endtask

  task automatic test_drop;
    send_b(4'b0100, 4'b0100);
    checks++;
    if (b_out_valid !== 1'b0 || b_cnt_err !== 16'd1) begin
      errors++; $display("FAIL drop_self: out_valid=%b cnt_err=%0d required 0 and 1", b_out_valid, b_cnt_err);
    end
    send_b(4'b1000, 4'b0001);
    checks++;
    if ({b_out_valid, b_out_type, b_out_ok, b_out_source} !== {1'b1, 2'd0, 1'b1, 4'b1000}) begin
      errors++; $display("FAIL drop_next: got %b required 10011000", {b_out_valid, b_out_type, b_out_ok, b_out_source});
    end
    checks++;
    if (b_cnt_sdp !== 16'd1) begin errors++; $display("FAIL drop_cnt_sdp: got %0d required 1", b_cnt_sdp); end
  endtask

  task automatic test_backpressure;
    int seen0 = a_seen;
    logic [3:0] s0, t0;
    send_a(4'b0001, 4'b0100);
    a_out_ready = 1'b0;
    s0 = a_out_source; t0 = a_out_target;
    a_in_source = 4'b0010; a_in_target = 4'b1000; a_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_source !== 4'b0001 || a_out_target !== 4'b0100) begin
        errors++; $display("FAIL bp_hold_%0d: rdy=%b vld=%b src=%b tgt=%b required 0 1 0001 0100",
                           i, a_in_ready, a_out_valid, a_out_source, a_out_target);
      end
    end
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    checks++;
    if (a_out_valid !== 1'b1 || a_out_source !== 4'b0010 || a_out_target !== 4'b1000) begin
      errors++; $display("FAIL bp_second: vld=%b src=%b tgt=%b required 1 0010 1000", a_out_valid, a_out_source, a_out_target);
    end
    @(posedge clk); #1;
    checks++;
    if (a_seen - seen0 != 2 || a_out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_count: outputs %0d vld=%b required 2 and 0", a_seen - seen0, a_out_valid);
    end
  endtask

  task automatic test_saturation;
    a_stat_clr = 1'b1;
    @(posedge clk); #1;
    a_stat_clr = 1'b0;
    checks++;
    if ({a_cnt_sdp, a_cnt_mdp, a_cnt_bdp, a_cnt_err} !== 16'd0) begin
      errors++; $display("FAIL clr: got %h required 0", {a_cnt_sdp, a_cnt_mdp, a_cnt_bdp, a_cnt_err});
    end
    for (int i = 0; i < 17; i++) send_a(4'b0001, 4'b0010);
    checks++;
    if (a_cnt_sdp !== 4'd15) begin errors++; $display("FAIL sat_sdp: got %0d required 15", a_cnt_sdp); end
    a_stat_clr = 1'b1;
    send_a(4'b0001, 4'b0010);
    a_stat_clr = 1'b0;
    checks++;
    if (a_cnt_sdp !== 4'd0) begin errors++; $display("FAIL clr_wins: got %0d required 0", a_cnt_sdp); end
  endtask

  task automatic test_reset_mid;
    send_a(4'b0001, 4'b0010);
    a_out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({a_out_valid, a_out_type, a_in_ready, a_cnt_sdp} !== {1'b0, 2'd3, 1'b0, 4'd0}) begin
      errors++; $display("FAIL rst_mid: vld/type/rdy/cnt %b required 0110000", {a_out_valid, a_out_type, a_in_ready, a_cnt_sdp});
    end
    qa.delete();
    qb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    a_out_ready = 1'b1;
    send_a(4'b0100, 4'b0001);
    checks++;
    if ({a_out_valid, a_out_type, a_out_ok, a_out_source, a_cnt_sdp} !== {1'b1, 2'd0, 1'b1, 4'b0100, 4'd1}) begin
      errors++; $display("FAIL rst_after: got %b required 100101000001",
                         {a_out_valid, a_out_type, a_out_ok, a_out_source, a_cnt_sdp});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_classify;
    test_back_to_back;
    test_drop;
    test_backpressure;
    test_saturation;
    test_reset_mid;
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++; $display("FAIL sb_leftover: qa=%0d qb=%0d required 0 0", qa.size(), qb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
